// File: rtl/tt_sweep_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Per-channel count width: must hold 2^n_in without overflow.
   function automatic int cnt_w(input int n_in);
      return n_in + 1;
   endfunction

   function automatic int hold_w(input int hold);
      return $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/tt_sweeper_if.sv
// Stimulus/result bundle between the sweeper (slave) and the bench/exercise side (master).
interface tt_sweeper_if
   import tt_sweep_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int N_CH = 8
);
   logic                           start;
   logic                           abort;
   logic [N_IN-1:0]                vec;
   logic [N_CH-1:0]                dut_y;
   logic [N_CH-1:0]                ref_y;
   logic                           busy;
   logic                           done;
   logic                           pass;
   logic [N_CH*cnt_w(N_IN)-1:0]    err_cnt;
   logic                           fail_valid;
   logic [N_IN-1:0]                fail_vec;
   logic [N_CH-1:0]                fail_mask;

   modport master (
      output start, abort, dut_y, ref_y,
      input  vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_mask
   );

   modport slave (
      input  start, abort, dut_y, ref_y,
      output vec, busy, done, pass, err_cnt, fail_valid, fail_vec, fail_mask
   );
endinterface

// File: rtl/tt_err_counter.sv
// Saturating per-channel mismatch counter with synchronous clear.
module tt_err_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment and hold at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {W{1'b0}};
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/tt_sweeper.sv
// Exhaustive truth-table sweeper with per-channel mismatch counts and first-fail capture.
// Define TT_SWEEP_GRAY_EN to issue vectors in reflected Gray-code order instead of binary.
module tt_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int N_CH = 8,
   parameter int HOLD = 1
) (
   input  logic          clk,
   input  logic          rst,
   tt_sweeper_if.slave   bus
);
   localparam int CW = cnt_w(N_IN);
   localparam int HW = hold_w(HOLD);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

   state_t              state_q;
   logic [N_IN-1:0]     idx_q;
   logic [HW-1:0]       hold_q;
   logic [N_IN-1:0]     vec_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;
   logic                fail_valid_q;
   logic [N_IN-1:0]     fail_vec_q;
   logic [N_CH-1:0]     fail_mask_q;

   logic                launch_s;
   logic                sample_s;
   logic                last_s;
   logic [N_CH-1:0]     mismatch_s;
   logic [N_CH-1:0]     inc_s;
   logic [N_CH*CW-1:0]  err_cnt_s;

   function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i);
`ifdef TT_SWEEP_GRAY_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   // Sweep control decodes; abort suppresses both launch and sampling.
   always_comb begin
      launch_s   = bus.start && !bus.abort && ((state_q == IDLE) || (state_q == DONE));
      sample_s   = (state_q == APPLY) && (hold_q == HOLD_LAST) && !bus.abort;
      last_s     = (idx_q == {N_IN{1'b1}});
      mismatch_s = bus.dut_y ^ bus.ref_y;
      if (sample_s) begin
         inc_s = mismatch_s;
      end else begin
         inc_s = {N_CH{1'b0}};
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      tt_err_counter #(.W(CW)) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (launch_s),
         .inc (inc_s[k]),
         .cnt (err_cnt_s[k*CW +: CW])
      );
   end

   // Sweep FSM with registered status and first-fail capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= {N_IN{1'b0}};
         hold_q       <= {HW{1'b0}};
         vec_q        <= {N_IN{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= {N_IN{1'b0}};
         fail_mask_q  <= {N_CH{1'b0}};
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (launch_s) begin
                  state_q      <= APPLY;
                  idx_q        <= {N_IN{1'b0}};
                  hold_q       <= {HW{1'b0}};
                  vec_q        <= map_vec({N_IN{1'b0}});
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  fail_valid_q <= 1'b0;
                  fail_vec_q   <= {N_IN{1'b0}};
                  fail_mask_q  <= {N_CH{1'b0}};
               end else begin
                  state_q <= state_q;
               end
            end
            APPLY: begin
               if (bus.abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (sample_s) begin
                  if ((mismatch_s != {N_CH{1'b0}}) && !fail_valid_q) begin
                     fail_valid_q <= 1'b1;
                     fail_vec_q   <= vec_q;
                     fail_mask_q  <= mismatch_s;
                  end else begin
                     fail_valid_q <= fail_valid_q;
                  end
                  if (last_s) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= !fail_valid_q && (mismatch_s == {N_CH{1'b0}});
                  end else begin
                     idx_q  <= idx_q + N_IN'(1);
                     vec_q  <= map_vec(idx_q + N_IN'(1));
                     hold_q <= {HW{1'b0}};
                  end
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.vec        = vec_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_cnt    = err_cnt_s;
   assign bus.fail_valid = fail_valid_q;
   assign bus.fail_vec   = fail_vec_q;
   assign bus.fail_mask  = fail_mask_q;

endmodule
